// File: rtl/radio_uplink_tx.sv
// Serial radio uplink transmitter: one sync pulse followed by NPAIRS 2-bit data
// pulses, each carrying an even-parity check bit; all timing in clk cycles.
module radio_uplink_tx #(
  parameter int NPAIRS  = 7,
  parameter int T_SETUP = 2,
  parameter int T_HIGH  = 4,
  parameter int T_LOW   = 4,
  parameter int T_GAP   = 8
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic [2*NPAIRS-1:0]   tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic                  err_inject,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  RPULSE,
  output logic                  RD1,
  output logic                  RD0,
  output logic                  RCHECK
);

  localparam int TMAX1 = (T_SETUP > T_HIGH) ? T_SETUP : T_HIGH;
  localparam int TMAX2 = (T_LOW > T_GAP) ? T_LOW : T_GAP;
  localparam int TMAX  = (TMAX1 > TMAX2) ? TMAX1 : TMAX2;
  localparam int PW    = $clog2(TMAX + 1);
  localparam int PAW   = (NPAIRS > 1) ? $clog2(NPAIRS) : 1;

  typedef enum logic [2:0] {
    IDLE, SYNC_SETUP, SYNC_HI, SYNC_LO, D_SETUP, D_HI, D_LO, GAP
  } state_e;

  function automatic logic even_parity(input logic [1:0] p);
    return ^p;
  endfunction

  state_e                state_q, state_d;
  logic [PW-1:0]         phase_q, phase_d;
  logic [PAW-1:0]        pair_q, pair_d;
  logic [2*NPAIRS-1:0]   word_q, word_d;
  logic                  inj_q, inj_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  rpulse_q, rpulse_d;
  logic                  rd1_q, rd1_d;
  logic                  rd0_q, rd0_d;
  logic                  rcheck_q, rcheck_d;
  logic [PW-1:0]         dur_s;
  logic                  last_s;
  logic [1:0]            pair_bits_s;

  // Sequencing: phase counter walks each state's duration, pair index advances per data pulse
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    pair_d  = pair_q;
    word_d  = word_q;
    inj_d   = inj_q;
    case (state_q)
      SYNC_SETUP, D_SETUP: dur_s = PW'(T_SETUP - 1);
      SYNC_HI, D_HI:       dur_s = PW'(T_HIGH - 1);
      SYNC_LO, D_LO:       dur_s = PW'(T_LOW - 1);
      GAP:                 dur_s = PW'(T_GAP - 1);
      default:             dur_s = {PW{1'b0}};
    endcase
    last_s = (phase_q == dur_s);

    if (state_q == IDLE) begin
      phase_d = {PW{1'b0}};
      if (tx_valid && ready_q) begin
        state_d = SYNC_SETUP;
        word_d  = tx_data;
        inj_d   = err_inject;
        pair_d  = {PAW{1'b0}};
      end else begin
        state_d = IDLE;
      end
    end else if (last_s) begin
      phase_d = {PW{1'b0}};
      case (state_q)
        SYNC_SETUP: state_d = SYNC_HI;
        SYNC_HI:    state_d = SYNC_LO;
        SYNC_LO: begin
          state_d = D_SETUP;
          pair_d  = {PAW{1'b0}};
        end
        D_SETUP:    state_d = D_HI;
        D_HI:       state_d = D_LO;
        D_LO: begin
          if (pair_q == PAW'(NPAIRS - 1)) begin
            state_d = GAP;
          end else begin
            state_d = D_SETUP;
            pair_d  = pair_q + PAW'(1);
          end
        end
        GAP:        state_d = IDLE;
        default:    state_d = IDLE;
      endcase
    end else begin
      phase_d = phase_q + PW'(1);
    end
  end

  // Output values for the coming cycle, decoded from the next state so the pins are registered
  always_comb begin
    pair_bits_s = 2'(word_d >> (2 * (NPAIRS - 1 - int'(pair_d))));
    ready_d  = 1'b0;
    busy_d   = 1'b1;
    done_d   = 1'b0;
    rpulse_d = 1'b0;
    rd1_d    = 1'b0;
    rd0_d    = 1'b0;
    rcheck_d = 1'b0;
    case (state_d)
      IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
      SYNC_SETUP, SYNC_HI, SYNC_LO: begin
        rpulse_d = (state_d == SYNC_HI);
        rd1_d    = 1'b1;
        rd0_d    = 1'b1;
        rcheck_d = 1'b1;
      end
      D_SETUP, D_HI, D_LO: begin
        rpulse_d = (state_d == D_HI);
        rd1_d    = pair_bits_s[1];
        rd0_d    = pair_bits_s[0];
        // Injected fault flips parity only on the final pair
        rcheck_d = even_parity(pair_bits_s) ^ (inj_d && (pair_d == PAW'(NPAIRS - 1)));
      end
      GAP: begin
        done_d = (phase_d == PW'(T_GAP - 1));
      end
      default: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q  <= IDLE;
      phase_q  <= {PW{1'b0}};
      pair_q   <= {PAW{1'b0}};
      word_q   <= {(2*NPAIRS){1'b0}};
      inj_q    <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rpulse_q <= 1'b0;
      rd1_q    <= 1'b0;
      rd0_q    <= 1'b0;
      rcheck_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      pair_q   <= pair_d;
      word_q   <= word_d;
      inj_q    <= inj_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rpulse_q <= rpulse_d;
      rd1_q    <= rd1_d;
      rd0_q    <= rd0_d;
      rcheck_q <= rcheck_d;
    end
  end

  assign tx_ready   = ready_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign RPULSE     = rpulse_q;
  assign RD1        = rd1_q;
  assign RD0        = rd0_q;
  assign RCHECK     = rcheck_q;

endmodule
